bf_data_port: RTL
=================

# bf_data_port

Data-side companion of the brainfuck core. Sits directly downstream of the core's data bus (`dp_adr`, `data_out`, `data_w_req`/`data_w_sel`, `data_r_req`/`data_r_sel`). It owns the 4096x16 tape RAM and routes `.`/`,` traffic to a byte-wide TX/RX stream toward the UART. It returns `data_in`/`data_den` and applies back-pressure through `data_w_wait`.

## Interface
Parameters:
- `ADDR_W`, 12: tape address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 16: tape cell width.
- `FIFO_DEPTH`, 16: TX and RX FIFO depth. Must be a power of two, ≥ 2. Ignored when `BF_IO_FIFO_EN` is undefined.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `s_rst`  in  1: synchronous soft reset, same cycle semantics as the core's.
- `dp_adr`  in  ADDR_W: tape address.
- `data_out`  in  DATA_W: write data from the core.
- `data_w_req`  in  1: write request, level; held while `data_w_wait`=1.
- `data_w_sel`  in  1: 0 selects the RAM, 1 selects TX (`.`).
- `data_w_wait`  out  1: write stall, combinational from registered FIFO state.
- `data_r_req`  in  1: read request, level.
- `data_r_sel`  in  1: 0 selects the RAM, 1 selects RX (`,`).
- `data_in`  out  DATA_W: read data, registered.
- `data_den`  out  1: read data valid, single-cycle pulse.
- `tx_data`  out  8: output byte.
- `tx_valid`  out  1: TX FIFO non-empty.
- `tx_ready`  in  1: UART accepts `tx_data` when `tx_valid & tx_ready`.
- `rx_data`  in  8: input byte.
- `rx_valid`  in  1: one-cycle strobe; no back-pressure.
- `rx_overrun`  out  1: sticky flag, set when an RX byte is dropped.

## Operation
- Reset values (`rst` or `s_rst`): `data_in`=0, `data_den`=0, `tx_valid`=0, `rx_overrun`=0, `data_w_wait`=0, both FIFOs empty, read FSM in IDLE. RAM contents are not reset; the core clears the RAM during its MEMI phase.
- RAM write: when `data_w_req & ~data_w_sel`, write `ram[dp_adr] <= data_out` that cycle. `data_w_wait` stays 0 for RAM writes.
- TX write: when `data_w_req & data_w_sel`:
  - TX not full: `data_w_wait`=0 and `data_out[7:0]` is pushed that cycle. Upper bits are discarded.
  - TX full: `data_w_wait`=1 and there is no push. The push happens in the first cycle the FIFO is not full.
  - A pop and push in the same cycle when full is not allowed; the push waits one cycle.
- Read FSM states: IDLE, WAIT_RX, RESP.
  - IDLE, `data_r_req & ~data_r_sel`, no RAM write this cycle → RESP. `data_in` <= `ram[dp_adr]`.
  - IDLE, RAM read while a RAM write occurs the same cycle → stay IDLE. The write wins; the request is re-sampled next cycle.
  - IDLE, `data_r_req & data_r_sel`, RX non-empty → RESP. `data_in` <= {8'h00, rx head}; pop.
  - IDLE, `data_r_req & data_r_sel`, RX empty → WAIT_RX.
  - WAIT_RX, RX non-empty → RESP with load and pop. `data_r_req` is not re-checked.
  - RESP → IDLE, with `data_den`=1 for this cycle only. `data_r_req` sampled during RESP is ignored, because the core's registered request is still high then.
- RX push: on `rx_valid`, if RX is not full, push. If full, drop the byte and set `rx_overrun`. A push and pop in the same cycle is legal when not full. A byte arriving at an empty FIFO is readable the next cycle.
- `s_rst` asserted during WAIT_RX or RESP returns the FSM to IDLE without a `data_den` pulse.

## Timing
- RAM read: request seen in cycle N → `data_den` and `data_in` valid in cycle N+1.
- RX read with data available: same N→N+1 latency. With RX empty: `data_den` fires 2 cycles after the byte arrives.
- TX latency: push in cycle N → `tx_valid`=1 in cycle N+1.

## Configuration
- `BF_IO_FIFO_EN` defined: TX and RX are FIFOs of `FIFO_DEPTH` entries.
- `BF_IO_FIFO_EN` undefined: each FIFO becomes a single-entry holding register with a full flag. All handshake rules above are unchanged; full means one entry held.

## Structure
- Package `bf_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults.
  - The read-FSM state enum.
  - The `.`, `,`, `+`, `-`, `[`, `]`, `<`, `>` opcode constants shared with the core.
- Sub-module `bf_sync_fifo` (parameters: width, depth; ports: push, pop, full, empty, count) is instantiated for TX and RX. It contains the `BF_IO_FIFO_EN` switch.

## Test plan
- RAM round trip: write 16'h1234 at address 12'h005 → read address 5 one cycle later → `data_den`=1 in cycle N+1 with `data_in`=16'h1234, then `data_den`=0.
- TX back-pressure: `FIFO_DEPTH`=16, `tx_ready`=0, 17 writes of 8'h41..8'h51:
  - `data_w_wait`=1 on the 17th write.
  - Raise `tx_ready`: the 17th push lands one cycle after the first pop.
  - Bytes drain in order 41..51.
- RX wait: read with `data_r_sel`=1 and RX empty → no `data_den`. Strobe `rx_data`=8'h7A at cycle M → `data_den` at M+2 with `data_in`=16'h007A.
- RX overrun: 17 `rx_valid` strobes with no reads → `rx_overrun`=1, FIFO holds the first 16 bytes. `s_rst` → `rx_overrun`=0 and FIFO empty.
- Held request: hold `data_r_req` high through RESP → exactly one `data_den` pulse per request.
- Soft reset mid-read: `s_rst` during WAIT_RX → FSM back to IDLE, no `data_den`. RAM value written before `s_rst` still reads back.

Source files
------------

// File: rtl/bf_pkg.sv
// Definitions shared by the brainfuck core and its data port: bus widths,
// the data-port read FSM states and the instruction opcodes.
package bf_pkg;

    localparam int BF_ADDR_W = 12;
    localparam int BF_DATA_W = 16;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT_RX,
        RD_RESP
    } rd_state_e;

    // ASCII encodings of the eight source characters
    localparam logic [7:0] OP_OUT   = 8'h2E;  // .
    localparam logic [7:0] OP_IN    = 8'h2C;  // ,
    localparam logic [7:0] OP_INC   = 8'h2B;  // +
    localparam logic [7:0] OP_DEC   = 8'h2D;  // -
    localparam logic [7:0] OP_LOOP  = 8'h5B;  // [
    localparam logic [7:0] OP_END   = 8'h5D;  // ]
    localparam logic [7:0] OP_LEFT  = 8'h3C;  // <
    localparam logic [7:0] OP_RIGHT = 8'h3E;  // >

endpackage

// File: rtl/bf_data_port_if.sv
// Core data bus plus the UART-side TX/RX byte streams of the data port.
// master = core/UART side, slave = bf_data_port.
interface bf_data_port_if
    import bf_pkg::*;
#(
    parameter int ADDR_W = BF_ADDR_W,
    parameter int DATA_W = BF_DATA_W
);
    logic [ADDR_W-1:0] dp_adr;
    logic [DATA_W-1:0] data_out;
    logic              data_w_req;
    logic              data_w_sel;
    logic              data_w_wait;
    logic              data_r_req;
    logic              data_r_sel;
    logic [DATA_W-1:0] data_in;
    logic              data_den;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_overrun;

    modport master (
        output dp_adr, data_out, data_w_req, data_w_sel, data_r_req, data_r_sel,
        output tx_ready, rx_data, rx_valid,
        input  data_w_wait, data_in, data_den, tx_data, tx_valid, rx_overrun
    );

    modport slave (
        input  dp_adr, data_out, data_w_req, data_w_sel, data_r_req, data_r_sel,
        input  tx_ready, rx_data, rx_valid,
        output data_w_wait, data_in, data_den, tx_data, tx_valid, rx_overrun
    );
endinterface

// File: rtl/bf_sync_fifo.sv
// Byte FIFO for the TX/RX streams. With BF_IO_FIFO_EN defined it is a DEPTH-entry
// ring buffer; otherwise a single holding register. Push is ignored when full.
module bf_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

`ifdef BF_IO_FIFO_EN
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush, doPop;

    // full is judged before any same-cycle pop, so a push into a full FIFO waits
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            if (doPush && !doPop)      count_q <= count_q + 1'b1;
            else if (doPop && !doPush) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end
`else
    logic [WIDTH-1:0] data_q;
    logic             full_q;

    assign full_o  = full_q;
    assign empty_o = ~full_q;
    assign count_o = CNT_W'(full_q);
    assign rdata_o = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end else if (push_i && !full_q) begin
            data_q <= wdata_i;
            full_q <= 1'b1;
        end else if (pop_i && full_q) begin
            full_q <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/bf_data_port.sv
// Data-side companion of the brainfuck core: tape RAM, read FSM and TX/RX byte
// buffers. Define BF_IO_FIFO_EN for FIFO_DEPTH-deep buffers (single entry otherwise).
module bf_data_port
    import bf_pkg::*;
#(
    parameter int ADDR_W     = BF_ADDR_W,
    parameter int DATA_W     = BF_DATA_W,
    parameter int FIFO_DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    input logic           s_rst,
    bf_data_port_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic              ramWr, txWrReq, txPush, txPop, txFull, txEmpty;
    logic              rxPop, rxFull, rxEmpty;
    logic [7:0]        rxHead;
    logic [CNT_W-1:0]  txCount, rxCount;
    logic              unusedCounts;
    rd_state_e         rdState_q, rdState_d;
    logic              loadRam, loadRx;
    logic [DATA_W-1:0] dataIn_q;
    logic              overrun_q, overrun_d;

    assign ramWr        = bus.data_w_req & ~bus.data_w_sel;
    assign txWrReq      = bus.data_w_req & bus.data_w_sel;
    assign txPush       = txWrReq & ~txFull;
    assign txPop        = ~txEmpty & bus.tx_ready;
    assign rxPop        = loadRx;
    assign unusedCounts = ^{txCount, rxCount};

    assign bus.data_w_wait = txWrReq & txFull & ~s_rst;
    assign bus.tx_valid    = ~txEmpty;
    assign bus.data_in     = dataIn_q;
    assign bus.data_den    = (rdState_q == RD_RESP) & ~s_rst;
    assign bus.rx_overrun  = overrun_q;

    bf_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .clr_i(s_rst),
        .push_i(txPush), .pop_i(txPop), .wdata_i(bus.data_out[7:0]),
        .rdata_o(bus.tx_data), .full_o(txFull), .empty_o(txEmpty), .count_o(txCount)
    );

    bf_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .clr_i(s_rst),
        .push_i(bus.rx_valid), .pop_i(rxPop), .wdata_i(bus.rx_data),
        .rdata_o(rxHead), .full_o(rxFull), .empty_o(rxEmpty), .count_o(rxCount)
    );

    always_ff @(posedge clk) begin
        if (ramWr) ram[bus.dp_adr] <= bus.data_out;
    end

    // A RAM read colliding with a RAM write stays in IDLE and is retried next cycle
    always_comb begin
        rdState_d = rdState_q;
        loadRam   = 1'b0;
        loadRx    = 1'b0;
        unique case (rdState_q)
            RD_IDLE: begin
                if (bus.data_r_req) begin
                    if (!bus.data_r_sel) begin
                        if (!ramWr) begin
                            rdState_d = RD_RESP;
                            loadRam   = 1'b1;
                        end
                    end else if (!rxEmpty) begin
                        rdState_d = RD_RESP;
                        loadRx    = 1'b1;
                    end else begin
                        rdState_d = RD_WAIT_RX;
                    end
                end
            end
            RD_WAIT_RX: begin
                if (!rxEmpty) begin
                    rdState_d = RD_RESP;
                    loadRx    = 1'b1;
                end
            end
            RD_RESP: rdState_d = RD_IDLE;
            default: rdState_d = RD_IDLE;
        endcase
        if (s_rst) begin
            rdState_d = RD_IDLE;
            loadRam   = 1'b0;
            loadRx    = 1'b0;
        end
    end

    always_comb begin
        overrun_d = overrun_q | (bus.rx_valid & rxFull);
        if (s_rst) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdState_q <= RD_IDLE;
            dataIn_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            rdState_q <= rdState_d;
            overrun_q <= overrun_d;
            if (s_rst)        dataIn_q <= '0;
            else if (loadRam) dataIn_q <= ram[bus.dp_adr];
            else if (loadRx)  dataIn_q <= {{(DATA_W-8){1'b0}}, rxHead};
        end
    end

endmodule
